qc_row_xor_accumulator: RTL and testbench



---
 rtl/qc_row_xor_accumulator.sv | 184 ++++++++++++++++++
 tb/tb_qc_row_xor_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qc_row_xor_accumulator.sv
// -----------------------------------------------------------------------------
// qc_row_xor_accumulator
//
// Purpose:
//   Downstream stage of the cyclic block rotator in the QC-LDPC encoder
//   datapath. For one base-matrix row it takes one rotated Z-bit sub-block
//   per column and XOR-accumulates them into a single parity sub-block. The
//   result goes to the parity write-back stage over a valid/ready handshake.
//   Data is MSB-aligned. Only the top `width` bits are significant, and all
//   bits below them are forced to zero.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset (highest priority)
//   start       in   begin a row; latches num_cols and the width mask
//   num_cols    in   beats in the row, legal range 1..MAX_COLS
//   width       in   effective sub-block bits (MSB-aligned), 0 = MAX_BLOCK_SIZE
//   in_valid    in   in_vector valid
//   in_ready    out  accumulator accepts a beat (registered)
//   in_vector   in   rotated sub-block from the rotator
//   out_valid   out  parity sub-block valid (registered)
//   out_ready   in   downstream accepts the result
//   out_vector  out  accumulated, masked parity sub-block
//   busy        out  high whenever the controller is not idle
//   err         out  one-cycle pulse on a protocol error
// -----------------------------------------------------------------------------
module qc_row_xor_accumulator #(
    parameter  int MAX_BLOCK_SIZE = 64,
    parameter  int MAX_COLS       = 24,
    localparam int WIDTH          = $clog2(MAX_BLOCK_SIZE),
    localparam int COL_W          = $clog2(MAX_COLS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [COL_W-1:0]          num_cols,
    input  logic [WIDTH-1:0]          width,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAX_BLOCK_SIZE-1:0] in_vector,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_BLOCK_SIZE-1:0] out_vector,
    output logic                      busy,
    output logic                      err
);

    localparam int                      SHAMT_W   = WIDTH + 1;
    localparam logic [COL_W-1:0]        MAX_COLS_C = COL_W'(MAX_COLS);
    localparam logic [MAX_BLOCK_SIZE-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [MAX_BLOCK_SIZE-1:0] r_acc;
    logic [MAX_BLOCK_SIZE-1:0] r_mask;
    logic [MAX_BLOCK_SIZE-1:0] r_out_vector;
    logic [COL_W-1:0]          r_cnt;
    logic [COL_W-1:0]          r_num_cols;
    logic                      r_out_valid;
    logic                      r_in_ready;
    logic                      r_busy;
    logic                      r_err;

    logic [SHAMT_W-1:0]        w_shamt;
    logic [MAX_BLOCK_SIZE-1:0] w_mask;
    logic                      w_start_legal;
    logic                      w_beat;
    logic                      w_last;
    logic                      w_hs;
    logic [MAX_BLOCK_SIZE-1:0] w_acc_next;

    // MSB-aligned mask. Shifting all-ones left by (Z - width) is the same as
    // ~((1 << (Z - width)) - 1). width==0 selects the full sub-block.
    always_comb begin
        w_shamt = SHAMT_W'(MAX_BLOCK_SIZE) - SHAMT_W'(width);
        if (width == '0) begin
            w_mask = ALL_ONES;
        end else begin
            w_mask = ALL_ONES << w_shamt;
        end
    end

    assign w_start_legal = (num_cols != '0) && (num_cols <= MAX_COLS_C);

    // in_ready is a registered decode of ACCUM, so accepting a beat never
    // depends combinationally on in_valid.
    assign w_beat     = in_valid & r_in_ready;
    assign w_last     = (r_cnt == (r_num_cols - COL_W'(1)));
    assign w_hs       = r_out_valid & out_ready;
    assign w_acc_next = r_acc ^ (in_vector & r_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_mask       <= '0;
            r_out_vector <= '0;
            r_cnt        <= '0;
            r_num_cols   <= '0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_legal) begin
                            r_num_cols <= num_cols;
                            r_mask     <= w_mask;
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    // A start here is a protocol error. The row keeps going.
                    if (start) begin
                        r_err <= 1'b1;
                    end
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + COL_W'(1);
                        if (w_last) begin
                            r_out_vector <= w_acc_next;
                            r_out_valid  <= 1'b1;
                            r_in_ready   <= 1'b0;
                            r_state      <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (start && w_start_legal) begin
                            // Back-to-back row: skip the IDLE bubble.
                            r_num_cols <= num_cols;
                            r_mask     <= w_mask;
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (start) begin
                                r_err <= 1'b1;
                            end
                        end
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_vector = r_out_vector;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_qc_row_xor_accumulator.sv
// -----------------------------------------------------------------------------
// tb_qc_row_xor_accumulator
//
// Directed self-checking bench for qc_row_xor_accumulator with Z=8 and four
// columns. Expected parity values come from a small XOR/mask model. They are
// queued when a row is driven and popped when the DUT presents out_valid.
// Inputs change on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_qc_row_xor_accumulator;

    localparam int MBS = 8;
    localparam int MC  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] num_cols;
    logic [2:0] width;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vector;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vector;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    qc_row_xor_accumulator #(
        .MAX_BLOCK_SIZE(MBS),
        .MAX_COLS      (MC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_cols  (num_cols),
        .width     (width),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vector(out_vector),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [7:0] fold(input int n, input int w,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m;
        logic [7:0] r;
        m = (w == 0) ? 8'hFF : ~((8'd1 << (8 - w)) - 8'd1);
        r = 8'h00;
        if (n > 0) r = r ^ (a & m);
        if (n > 1) r = r ^ (b & m);
        if (n > 2) r = r ^ (c & m);
        if (n > 3) r = r ^ (d & m);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, out_vector);
        end else begin
            chk(tag, out_vector, sb.pop_front());
        end
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    endtask

    task automatic start_row(input int n, input int w);
        start    = 1'b1;
        num_cols = 3'(n);
        width    = 3'(w);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] v);
        in_valid  = 1'b1;
        in_vector = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_cols  = '0;
        width     = '0;
        in_valid  = 1'b0;
        in_vector = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_in_ready",  8'(in_ready),  8'd0);
        chk("rst_busy",      8'(busy),      8'd0);
        chk("rst_err",       8'(err),       8'd0);
        chk("rst_out_vec",   out_vector,    8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Row 1: three back-to-back beats, full width, 1-cycle latency.
        start_row(3, 0);
        chk("r1_in_ready", 8'(in_ready), 8'd1);
        chk("r1_busy",     8'(busy),     8'd1);
        sb.push_back(fold(3, 0, 8'hF0, 8'h3C, 8'h01, 8'h00));
        beat(8'hF0);
        beat(8'h3C);
        beat(8'h01);
        chk("r1_latency", 8'(out_valid), 8'd1);
        pop_check("r1_vec");
        @(negedge clk);
        chk("r1_busy_fall", 8'(busy),      8'd0);
        chk("r1_valid_fall", 8'(out_valid), 8'd0);

        // Row 2: width 4 keeps only the high nibble.
        start_row(2, 4);
        sb.push_back(fold(2, 4, 8'hFF, 8'h0F, 8'h00, 8'h00));
        beat(8'hFF);
        beat(8'h0F);
        wait_out("r2");
        pop_check("r2_vec");
        @(negedge clk);

        // Row 3: single beat, result held under backpressure.
        out_ready = 1'b0;
        start_row(1, 0);
        sb.push_back(fold(1, 0, 8'hAA, 8'h00, 8'h00, 8'h00));
        beat(8'hAA);
        for (int i = 0; i < 5; i++) begin
            chk("r3_hold_valid", 8'(out_valid), 8'd1);
            chk("r3_hold_vec",   out_vector,    8'hAA);
            chk("r3_hold_rdy",   8'(in_ready),  8'd0);
            @(negedge clk);
        end
        pop_check("r3_vec");
        // Handshake and a new start in the same cycle.
        out_ready = 1'b1;
        start     = 1'b1;
        num_cols  = 3'd2;
        width     = 3'd0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_in_ready",  8'(in_ready),  8'd1);
        chk("b2b_busy",      8'(busy),      8'd1);
        chk("b2b_valid_low", 8'(out_valid), 8'd0);
        chk("b2b_err",       8'(err),       8'd0);
        sb.push_back(fold(2, 0, 8'h12, 8'h34, 8'h00, 8'h00));
        beat(8'h12);
        beat(8'h34);
        wait_out("b2b");
        pop_check("b2b_vec");
        @(negedge clk);

        // Illegal starts while idle.
        start_row(0, 0);
        chk("zero_err",  8'(err),  8'd1);
        chk("zero_busy", 8'(busy), 8'd0);
        @(negedge clk);
        chk("zero_err_pulse", 8'(err), 8'd0);
        start_row(5, 0);
        chk("over_err",  8'(err),  8'd1);
        chk("over_busy", 8'(busy), 8'd0);
        @(negedge clk);

        // Start during ACCUM and during HOLD is ignored but flagged.
        start_row(3, 0);
        sb.push_back(fold(3, 0, 8'h11, 8'h22, 8'h44, 8'h00));
        beat(8'h11);
        start    = 1'b1;
        num_cols = 3'd1;
        @(negedge clk);
        start = 1'b0;
        chk("acc_start_err",  8'(err),      8'd1);
        chk("acc_start_busy", 8'(busy),     8'd1);
        chk("acc_start_rdy",  8'(in_ready), 8'd1);
        out_ready = 1'b0;
        beat(8'h22);
        beat(8'h44);
        start    = 1'b1;
        num_cols = 3'd2;
        @(negedge clk);
        start = 1'b0;
        chk("hold_start_err",   8'(err),       8'd1);
        chk("hold_start_valid", 8'(out_valid), 8'd1);
        pop_check("acc_start_vec");
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_start_idle", 8'(busy), 8'd0);

        // Gapped beats, including a counted all-zero beat.
        start_row(4, 0);
        sb.push_back(fold(4, 0, 8'h81, 8'h00, 8'h81, 8'h7E));
        beat(8'h81);
        @(negedge clk);
        @(negedge clk);
        chk("gap_rdy",   8'(in_ready),  8'd1);
        chk("gap_valid", 8'(out_valid), 8'd0);
        beat(8'h00);
        @(negedge clk);
        @(negedge clk);
        beat(8'h81);
        @(negedge clk);
        @(negedge clk);
        beat(8'h7E);
        chk("gap_latency", 8'(out_valid), 8'd1);
        pop_check("gap_vec");
        @(negedge clk);

        // Reset mid-row discards partial state.
        start_row(3, 0);
        beat(8'h0F);
        beat(8'hF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy",  8'(busy),      8'd0);
        chk("mid_rst_rdy",   8'(in_ready),  8'd0);
        chk("mid_rst_valid", 8'(out_valid), 8'd0);
        chk("mid_rst_vec",   out_vector,    8'h00);
        start_row(1, 0);
        sb.push_back(fold(1, 0, 8'h55, 8'h00, 8'h00, 8'h00));
        beat(8'h55);
        wait_out("post_rst");
        pop_check("post_rst_vec");
        @(negedge clk);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
